gap_state_detector: RTL and testbench

Classifies the EDM gap from the 12-bit moving-average gap voltage into OPEN / NORMAL / SHORT states, using hysteresis thresholds and a programmable debounce. It sits directly downstream of the channel-2 averaging filter and feeds the servo and pulse-generator control logic. It emits one-cycle entry pulses on state changes and keeps a saturating short-circuit event counter.

---
 rtl/gap_pkg.sv | 25 ++
 rtl/gap_debounce.sv | 65 ++++++
 rtl/gap_state_detector.sv | 144 ++++++++++++++
 tb/tb_gap_state_detector.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gap_pkg.sv
// Shared definitions for the EDM gap state detector.
//   - gap state encodings (OPEN / NORMAL / SHORT; 2'b11 is never produced)
//   - default widths for voltage samples, debounce length and event counter
//   - default hysteresis thresholds for the 12-bit ADC path
package gap_pkg;

  localparam int GAP_DATA_W = 12;
  localparam int GAP_DEB_W  = 8;
  localparam int GAP_CNT_W  = 16;

  typedef enum logic [1:0] {
    GAP_OPEN   = 2'b00,
    GAP_NORMAL = 2'b01,
    GAP_SHORT  = 2'b10
  } gap_state_e;

  localparam int GAP_ST_W = $bits(gap_state_e);

  // Ordering must hold: SHORT_LO <= SHORT_HI < OPEN_LO <= OPEN_HI.
  localparam logic [GAP_DATA_W-1:0] DEF_SHORT_LO_TH = 12'd200;
  localparam logic [GAP_DATA_W-1:0] DEF_SHORT_HI_TH = 12'd300;
  localparam logic [GAP_DATA_W-1:0] DEF_OPEN_LO_TH  = 12'd2800;
  localparam logic [GAP_DATA_W-1:0] DEF_OPEN_HI_TH  = 12'd3000;

endpackage

// File: rtl/gap_debounce.sv
// Debounce for the gap state machine.
// Tracks the previous candidate state and how many consecutive valid samples
// have repeated it, and raises commit_o (combinational) on the valid sample
// whose count reaches len_i.
//   clk, rst_n  clock, asynchronous active-low reset
//   valid_i     a stage-2 sample is present this cycle
//   hold_i      configuration error: count held at 0, candidate parked on state
//   cand_i      candidate state computed from the current sample
//   state_i     currently committed state
//   len_i       extra confirming samples required (0 = commit on first)
//   commit_o    take cand_i as the new state at the next clock edge
module gap_debounce
  import gap_pkg::*;
#(
  parameter int                DEB_W    = GAP_DEB_W,
  parameter int                ST_W     = GAP_ST_W,
  parameter logic [ST_W-1:0]   RST_CAND = GAP_OPEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic             hold_i,
  input  logic [ST_W-1:0]  cand_i,
  input  logic [ST_W-1:0]  state_i,
  input  logic [DEB_W-1:0] len_i,
  output logic             commit_o
);

  logic [ST_W-1:0]  cand_q;
  logic [DEB_W-1:0] cnt_q;
  logic [DEB_W-1:0] cnt_d;
  logic             restart;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    restart  = 1'b0;
    cnt_d    = '0;
    commit_o = 1'b0;

    // A run starts over when nothing would change or the candidate switched.
    restart = (cand_i == state_i) || (cand_i != cand_q);
    cnt_d   = restart ? '0 : cnt_q + DEB_W'(1);
    // >= rather than == so a shortened len_i mid-run still commits.
    commit_o = valid_i && !hold_i && (cand_i != state_i) && (cnt_d >= len_i);
  end

  // NOTE: flops are updated with non-blocking assignments only, so every
  // always_ff reads the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand_q <= RST_CAND;
      cnt_q  <= '0;
    end else if (hold_i) begin
      // Parking the candidate on the state makes the first sample after the
      // error clears start a fresh run.
      cand_q <= state_i;
      cnt_q  <= '0;
    end else if (valid_i) begin
      cand_q <= cand_i;
      cnt_q  <= commit_o ? '0 : cnt_d;
    end
  end

endmodule

// File: rtl/gap_state_detector.sv
// Classifies the moving-average gap voltage into OPEN / NORMAL / SHORT with
// hysteresis and debounce, emits one-cycle entry pulses and counts SHORT
// entries with saturation.
//   clk, rst_n               clock, asynchronous active-low reset
//   filtered_vol, sample_en  averaged gap voltage and its qualifier
//   short_lo_th/short_hi_th  SHORT entry (below lo) / exit (above hi)
//   open_lo_th/open_hi_th    OPEN exit (below lo) / entry (above hi)
//   debounce_len             extra confirming samples before a transition
//   clear_cnt                synchronous clear of short_cnt
//   gap_state, state_valid   committed state, high after first classification
//   short_pulse, open_pulse  one cycle on entry to SHORT / OPEN
//   short_cnt                saturating SHORT entry count
//   cfg_err                  registered threshold ordering violation
module gap_state_detector
  import gap_pkg::*;
#(
  parameter int DATA_W = GAP_DATA_W,
  parameter int DEB_W  = GAP_DEB_W,
  parameter int CNT_W  = GAP_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] filtered_vol,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] short_lo_th,
  input  logic [DATA_W-1:0] short_hi_th,
  input  logic [DATA_W-1:0] open_lo_th,
  input  logic [DATA_W-1:0] open_hi_th,
  input  logic [DEB_W-1:0]  debounce_len,
  input  logic              clear_cnt,
  output logic [1:0]        gap_state,
  output logic              state_valid,
  output logic              short_pulse,
  output logic              open_pulse,
  output logic [CNT_W-1:0]  short_cnt,
  output logic              cfg_err
);

  logic [DATA_W-1:0] v_q;
  logic              vld_q;
  gap_state_e        state_q;
  gap_state_e        cand;
  logic              commit;
  logic              cfg_bad;
  logic              cfg_err_q;
  logic              state_valid_q;
  logic              short_pulse_q;
  logic              open_pulse_q;
  logic [CNT_W-1:0]  short_cnt_q;
  logic [CNT_W-1:0]  short_cnt_d;

  // Stage 1: sample register; vld_q marks a fresh v_q for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= sample_en;
      if (sample_en) v_q <= filtered_vol;
    end
  end

  // Stage 2: candidate from the current state. The thresholds used depend on
  // where we are, which gives the hysteresis; equality never crosses.
  always_comb begin
    cand = state_q;
    case (state_q)
      GAP_OPEN: begin
        if (v_q < short_lo_th)     cand = GAP_SHORT;
        else if (v_q < open_lo_th) cand = GAP_NORMAL;
      end
      GAP_NORMAL: begin
        if (v_q < short_lo_th)     cand = GAP_SHORT;
        else if (v_q > open_hi_th) cand = GAP_OPEN;
      end
      GAP_SHORT: begin
        if (v_q > open_hi_th)       cand = GAP_OPEN;
        else if (v_q > short_hi_th) cand = GAP_NORMAL;
      end
      default: cand = GAP_OPEN;
    endcase
  end

  assign cfg_bad = !((short_lo_th <= short_hi_th) &&
                     (short_hi_th <  open_lo_th)  &&
                     (open_lo_th  <= open_hi_th));

  gap_debounce #(
    .DEB_W    (DEB_W),
    .ST_W     (GAP_ST_W),
    .RST_CAND (GAP_OPEN)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (vld_q),
    .hold_i   (cfg_err_q),
    .cand_i   (cand),
    .state_i  (state_q),
    .len_i    (debounce_len),
    .commit_o (commit)
  );

  // A SHORT entry wins over a coincident clear so the event is not lost.
  always_comb begin
    short_cnt_d = short_cnt_q;
    if (commit && (cand == GAP_SHORT)) begin
      if (clear_cnt)         short_cnt_d = CNT_W'(1);
      else if (&short_cnt_q) short_cnt_d = short_cnt_q;
      else                   short_cnt_d = short_cnt_q + CNT_W'(1);
    end else if (clear_cnt) begin
      short_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= GAP_OPEN;
      state_valid_q <= 1'b0;
      short_pulse_q <= 1'b0;
      open_pulse_q  <= 1'b0;
      short_cnt_q   <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      cfg_err_q     <= cfg_bad;
      short_pulse_q <= 1'b0;
      open_pulse_q  <= 1'b0;
      short_cnt_q   <= short_cnt_d;
      if (vld_q) state_valid_q <= 1'b1;
      if (commit) begin
        state_q       <= cand;
        short_pulse_q <= (cand == GAP_SHORT);
        open_pulse_q  <= (cand == GAP_OPEN);
      end
    end
  end

  assign gap_state   = state_q;
  assign state_valid = state_valid_q;
  assign short_pulse = short_pulse_q;
  assign open_pulse  = open_pulse_q;
  assign short_cnt   = short_cnt_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_gap_state_detector.sv
// Self-checking bench for gap_state_detector: directed steps from the test
// plan followed by a randomized phase, all compared every cycle against a
// queue-based reference model. A second instance with a 5-bit counter
// exercises short_cnt saturation within a short run.
module tb_gap_state_detector;
  import gap_pkg::*;

  localparam int SAT_W = 5;
  localparam int SAT_MAX = (1 << SAT_W) - 1;
  localparam int CNT_MAX = 65535;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] filtered_vol;
  logic        sample_en;
  logic [11:0] slo, shi, olo, ohi;
  logic [7:0]  deb;
  logic        clear_cnt;

  logic [1:0]  gs, gs2;
  logic        sv, sp, op, ce, sv2, sp2, op2, ce2;
  logic [15:0] scnt;
  logic [SAT_W-1:0] scnt2;

  always #5 clk = ~clk;

  gap_state_detector dut (
    .clk(clk), .rst_n(rst_n), .filtered_vol(filtered_vol), .sample_en(sample_en),
    .short_lo_th(slo), .short_hi_th(shi), .open_lo_th(olo), .open_hi_th(ohi),
    .debounce_len(deb), .clear_cnt(clear_cnt),
    .gap_state(gs), .state_valid(sv), .short_pulse(sp), .open_pulse(op),
    .short_cnt(scnt), .cfg_err(ce)
  );

  gap_state_detector #(.CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n), .filtered_vol(filtered_vol), .sample_en(sample_en),
    .short_lo_th(slo), .short_hi_th(shi), .open_lo_th(olo), .open_hi_th(ohi),
    .debounce_len(deb), .clear_cnt(clear_cnt),
    .gap_state(gs2), .state_valid(sv2), .short_pulse(sp2), .open_pulse(op2),
    .short_cnt(scnt2), .cfg_err(ce2)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  gap_state_e m_state;
  bit         m_valid, m_sp, m_op, m_cfg;
  int         m_cnt, m_cnt_sat;
  gap_state_e run_q[$];   // consecutive identical candidates differing from m_state
  bit         pend_en;    // sample captured at the previous edge, judged at this one
  int         pend_v;

  int edge_vals[12] = '{199, 200, 201, 299, 300, 301, 2799, 2800, 2801, 2999, 3000, 3001};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic gap_state_e classify(gap_state_e cur, int v);
    bit below_short = v < int'(slo);
    bit above_short = v > int'(shi);
    bit below_open  = v < int'(olo);
    bit above_open  = v > int'(ohi);
    case (cur)
      GAP_OPEN:   return below_short ? GAP_SHORT : (below_open ? GAP_NORMAL : GAP_OPEN);
      GAP_NORMAL: return below_short ? GAP_SHORT : (above_open ? GAP_OPEN : GAP_NORMAL);
      default:    return above_open ? GAP_OPEN : (above_short ? GAP_NORMAL : GAP_SHORT);
    endcase
  endfunction

  function automatic void model_reset();
    m_state = GAP_OPEN; m_valid = 0; m_sp = 0; m_op = 0; m_cfg = 0;
    m_cnt = 0; m_cnt_sat = 0; run_q.delete(); pend_en = 0; pend_v = 0;
  endfunction

  function automatic void model_edge();
    bit cfg_new;
    bit s_entry;
    gap_state_e c;
    cfg_new = !((slo <= shi) && (shi < olo) && (olo <= ohi));
    m_sp = 0; m_op = 0; s_entry = 0;
    if (m_cfg) begin
      run_q.delete();
    end else if (pend_en) begin
      c = classify(m_state, pend_v);
      if (c == m_state) begin
        run_q.delete();
      end else begin
        if (run_q.size() != 0 && run_q[$] != c) run_q.delete();
        run_q.push_back(c);
        // debounce_len extra samples beyond the first qualifying one
        if (run_q.size() > int'(deb)) begin
          m_state = c;
          run_q.delete();
          m_sp = (c == GAP_SHORT);
          m_op = (c == GAP_OPEN);
          s_entry = m_sp;
        end
      end
    end
    if (pend_en) m_valid = 1;
    if (s_entry) begin
      m_cnt     = clear_cnt ? 1 : ((m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1);
      m_cnt_sat = clear_cnt ? 1 : ((m_cnt_sat == SAT_MAX) ? SAT_MAX : m_cnt_sat + 1);
    end else if (clear_cnt) begin
      m_cnt = 0; m_cnt_sat = 0;
    end
    m_cfg   = cfg_new;
    pend_en = sample_en;
    pend_v  = int'(filtered_vol);
  endfunction

  task automatic check_all();
    check("gap_state",   gs,   m_state);
    check("state_valid", sv,   m_valid);
    check("short_pulse", sp,   m_sp);
    check("open_pulse",  op,   m_op);
    check("short_cnt",   scnt, m_cnt);
    check("cfg_err",     ce,   m_cfg);
    check("sat_cnt",     scnt2, m_cnt_sat);
    check("sat_flags",   {gs2, sv2, sp2, op2, ce2}, {m_state, m_valid, m_sp, m_op, m_cfg});
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Cycles until gap_state reaches exp; -1 when the budget expires.
  task automatic wait_state(input gap_state_e exp, input int max_cyc, output int lat);
    lat = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      cycle();
      if (gs === exp) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int v;
    int hold;

    filtered_vol = 12'd3500; sample_en = 1'b1; clear_cnt = 1'b0; deb = 8'd3;
    slo = DEF_SHORT_LO_TH; shi = DEF_SHORT_HI_TH; olo = DEF_OPEN_LO_TH; ohi = DEF_OPEN_HI_TH;
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #1 check_all();
    cycle();
    rst_n = 1'b1;

    // Constant 3500: stays OPEN, state_valid at cycle 2
    cycle();
    check("valid_c1", sv, 1'b0);
    cycle();
    check("valid_c2", sv, 1'b1);
    run(6);
    check("open_hold", gs, GAP_OPEN);

    // 3500 -> 1500: NORMAL 5 cycles after the step
    filtered_vol = 12'd1500;
    wait_state(GAP_NORMAL, 20, lat);
    check("normal_lat", lat, 5);
    run(3);

    // 150 x3 then 250: interrupted run, no transition
    filtered_vol = 12'd150;
    run(3);
    filtered_vol = 12'd250;
    run(6);
    check("no_short", gs, GAP_NORMAL);

    // 150 held: SHORT after 4 samples
    filtered_vol = 12'd150;
    wait_state(GAP_SHORT, 20, lat);
    check("short_lat", lat, 5);
    check("short_pulse_on", sp, 1'b1);
    check("short_cnt_1", scnt, 1);
    cycle();
    check("short_pulse_off", sp, 1'b0);

    // Hysteresis on SHORT exit, then NORMAL, then OPEN boundary
    filtered_vol = 12'd250;
    run(10);
    check("short_hyst", gs, GAP_SHORT);
    filtered_vol = 12'd310;
    wait_state(GAP_NORMAL, 20, lat);
    check("short_exit_lat", lat, 5);
    filtered_vol = 12'd3000;
    run(10);
    check("open_eq_th", gs, GAP_NORMAL);
    filtered_vol = 12'd3001;
    wait_state(GAP_OPEN, 20, lat);
    check("open_lat", lat, 5);
    check("open_pulse_on", op, 1'b1);

    // Repeated SHORT entries with no debounce: saturation of the small counter
    deb = 8'd0;
    for (int i = 0; i < 40; i++) begin
      filtered_vol = 12'd150;  run(2);
      filtered_vol = 12'd3001; run(2);
    end
    check("cnt_41", scnt, 41);
    check("sat_cnt_max", scnt2, SAT_MAX);

    // clear_cnt coinciding with a SHORT entry
    filtered_vol = 12'd150;
    cycle();
    clear_cnt = 1'b1;
    cycle();
    clear_cnt = 1'b0;
    check("clr_entry", scnt, 1);
    check("clr_entry_sat", scnt2, 1);
    filtered_vol = 12'd3001;
    run(2);
    clear_cnt = 1'b1;
    cycle();
    clear_cnt = 1'b0;
    check("clr_only", scnt, 0);

    // Randomized phase
    for (int blk = 0; blk < 80; blk++) begin
      deb = 8'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       v = int'($urandom_range(0, 260));
        1:       v = int'($urandom_range(240, 2850));
        2:       v = int'($urandom_range(2750, 4095));
        default: v = edge_vals[$urandom_range(0, 11)];
      endcase
      hold = int'($urandom_range(1, 8));
      for (int k = 0; k < hold; k++) begin
        filtered_vol = 12'(v);
        sample_en = ($urandom_range(0, 3) != 0);
        clear_cnt = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end
    sample_en = 1'b1;
    clear_cnt = 1'b0;

    // Threshold ordering violation freezes the FSM
    deb = 8'd0;
    filtered_vol = 12'd1500;
    run(4);
    check("cfg_pre", gs, GAP_NORMAL);
    shi = 12'd2900;
    cycle();
    check("cfg_err_set", ce, 1'b1);
    filtered_vol = 12'd150;
    run(10);
    check("cfg_frozen", gs, GAP_NORMAL);
    shi = DEF_SHORT_HI_TH;
    cycle();
    check("cfg_err_clr", ce, 1'b0);
    cycle();
    check("cfg_resume", gs, GAP_SHORT);

    // Asynchronous reset in the middle of a debounce run
    deb = 8'd3;
    filtered_vol = 12'd3500;
    run(3);
    rst_n = 1'b0;
    #1;
    check("rst_state", gs, GAP_OPEN);
    check("rst_valid", sv, 1'b0);
    check("rst_spulse", sp, 1'b0);
    check("rst_opulse", op, 1'b0);
    check("rst_cnt", scnt, 0);
    check("rst_cfg", ce, 1'b0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    run(8);
    check("post_rst_open", gs, GAP_OPEN);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
